// File: rtl/afifo_rd_pkg.sv
// Shared definitions for the async-FIFO read-side byte burst reader.
package afifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  // Ceiling log2, used to size pointers and counters from depth parameters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/afifo_rd_prefetch_buf.sv
// Circular prefetch buffer: absorbs FIFO read latency and output backpressure.
// The caller never pushes into a full buffer nor pops an empty one.
module afifo_rd_prefetch_buf
  import afifo_rd_pkg::*;
#(
  parameter int c_DEPTH = 4,
  localparam int c_PTR_W = clog2(c_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       wr_data,
  input  logic             pop,
  output logic [7:0]       head,
  output logic [c_PTR_W:0] count
);

  localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
  localparam logic [c_PTR_W:0]   c_CNT_ONE = 1;

  logic [7:0]         mem [c_DEPTH];
  logic [c_PTR_W-1:0] wr_ptr;
  logic [c_PTR_W-1:0] rd_ptr;

  // Storage, pointers (wrap naturally at the power-of-2 depth) and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + c_PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + c_PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + c_CNT_ONE;
        2'b01:   count <= count - c_CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/afifo_byte_burst_reader.sv
// Read-side consumer of the 32-in/8-out async FIFO: drains one commanded burst
// of bytes per start into a valid/ready byte stream, marking the last byte.
//
// Stream handshake: a byte transfers on a rising edge where m_valid && m_ready.
// Once m_valid is high it stays high, and m_data/m_last hold, until the
// transfer happens; m_valid never depends on m_ready.
module afifo_byte_burst_reader
  import afifo_rd_pkg::*;
#(
  parameter int c_RD_LATENCY = 1,
  parameter int c_BUF_DEPTH  = 4,
  parameter int c_LEN_WIDTH  = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  input  logic                   start,
  input  logic [c_LEN_WIDTH-1:0] burst_len,
  output logic                   busy,
  output logic                   done,
  output logic                   fifo_rd_en,
  input  logic [7:0]             fifo_rd_data,
  input  logic                   fifo_rd_empty,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [7:0]             m_data,
  output logic                   m_last
);

  localparam int c_CNT_W = clog2(c_BUF_DEPTH) + 1;
  localparam int c_INF_W = clog2(c_RD_LATENCY + 1);
  localparam logic [c_LEN_WIDTH-1:0] c_LEN_ONE = 1;

  rd_state_t               state;
  rd_state_t               state_next;
  logic [c_LEN_WIDTH-1:0]  issue_rem;
  logic [c_LEN_WIDTH-1:0]  out_rem;
  logic [c_RD_LATENCY-1:0] lat_pipe;
  logic [c_INF_W-1:0]      inflight;
  logic [c_CNT_W-1:0]      buf_count;
  logic [7:0]              buf_head;
  logic                    start_ok;
  logic                    pop;
  logic                    room;

  assign start_ok = start && (burst_len != '0);
  assign pop      = m_valid && m_ready;

  // Reads already issued but not yet landed in the buffer.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < c_RD_LATENCY; i++) inflight = inflight + c_INF_W'(lat_pipe[i]);
  end

  // Reserving buffer space for in-flight reads keeps the buffer from overflowing
  // even when the stream is stalled for a long time.
  assign room       = (int'(inflight) + int'(buf_count)) < c_BUF_DEPTH;
  assign fifo_rd_en = (state == RUN) && !fifo_rd_empty && (issue_rem != '0) && room;

  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);
  assign m_valid = (buf_count != '0);
  assign m_data  = buf_head;
  assign m_last  = m_valid && (out_rem == c_LEN_ONE);

  // State register.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state logic; DRAIN leaves on the final handshake so done follows it directly.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (issue_rem == '0) state_next = DRAIN;
      DRAIN:   if ((out_rem == '0) || (pop && (out_rem == c_LEN_ONE))) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst counters: reads still to issue and bytes still to hand over.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      issue_rem <= '0;
      out_rem   <= '0;
    end else if ((state == IDLE) && start_ok) begin
      issue_rem <= burst_len;
      out_rem   <= burst_len;
    end else begin
      if (fifo_rd_en) issue_rem <= issue_rem - c_LEN_ONE;
      if (pop && (out_rem != '0)) out_rem <= out_rem - c_LEN_ONE;
    end
  end

  // Latency pipe: the tail bit marks the cycle fifo_rd_data is valid.
  if (c_RD_LATENCY == 1) begin : g_lat1
    always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) lat_pipe <= '0;
      else           lat_pipe <= fifo_rd_en;
    end
  end else begin : g_latn
    always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) lat_pipe <= '0;
      else           lat_pipe <= {lat_pipe[c_RD_LATENCY-2:0], fifo_rd_en};
    end
  end

  afifo_rd_prefetch_buf #(
    .c_DEPTH (c_BUF_DEPTH)
  ) u_buf (
    .clk     (rd_clk),
    .rst_n   (rd_rst_n),
    .push    (lat_pipe[c_RD_LATENCY-1]),
    .wr_data (fifo_rd_data),
    .pop     (pop),
    .head    (buf_head),
    .count   (buf_count)
  );

endmodule

// File: tb/tb_afifo_byte_burst_reader.sv
// Bench for afifo_byte_burst_reader: two DUTs (read latency 1 and 2) share the
// stimulus; each has its own FIFO model and burst-level reference model.
module tb_afifo_byte_burst_reader;

  localparam int c_DEPTH = 4;
  localparam int c_LW    = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            start;
  logic            m_ready;
  logic [c_LW-1:0] burst_len;
  logic [1:0]      busy, done, rd_en, empty, m_valid, m_last;
  logic [1:0][7:0] rd_data, m_data;

  afifo_byte_burst_reader #(.c_RD_LATENCY(1), .c_BUF_DEPTH(c_DEPTH), .c_LEN_WIDTH(c_LW)) u_dut_l1 (
    .rd_clk(clk), .rd_rst_n(rst_n), .start(start), .burst_len(burst_len),
    .busy(busy[0]), .done(done[0]), .fifo_rd_en(rd_en[0]), .fifo_rd_data(rd_data[0]),
    .fifo_rd_empty(empty[0]), .m_valid(m_valid[0]), .m_ready(m_ready),
    .m_data(m_data[0]), .m_last(m_last[0]));

  afifo_byte_burst_reader #(.c_RD_LATENCY(2), .c_BUF_DEPTH(c_DEPTH), .c_LEN_WIDTH(c_LW)) u_dut_l2 (
    .rd_clk(clk), .rd_rst_n(rst_n), .start(start), .burst_len(burst_len),
    .busy(busy[1]), .done(done[1]), .fifo_rd_en(rd_en[1]), .fifo_rd_data(rd_data[1]),
    .fifo_rd_empty(empty[1]), .m_valid(m_valid[1]), .m_ready(m_ready),
    .m_data(m_data[1]), .m_last(m_last[1]));

  // ---------------- bench state ----------------
  int n_pass = 0;
  int n_total = 0;

  logic [7:0] fq[2][$];     // FIFO contents per DUT
  logic [7:0] exp_q[2][$];  // bytes still to appear on each stream, in order
  logic [7:0] s1[2];        // FIFO output register stage (latency 2)
  logic       rd_en_s[2];

  logic mb_busy[2], mb_done[2], done_seen[2];
  int   rem_out[2], len_cur[2], reads[2], hs[2], idx[2];
  int   first_rd[2], first_valid[2], last_hs_idx[2], last_byte[2];
  logic prev_stall[2], prev_last[2];
  logic [7:0] prev_data[2];

  logic            drv_rst_n, drv_start, drv_ready, drv_push;
  logic [c_LW-1:0] drv_len;
  logic [31:0]     drv_word;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
  endtask

  // FIFO behaviour at a rising edge: pop on the previous cycle's rd_en.
  task automatic fifo_edge();
    logic [7:0] b;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        fq[i].delete();
        s1[i] = '0;
        rd_data[i] = '0;
      end else begin
        if (i == 1) rd_data[i] = s1[i];
        if (rd_en_s[i]) begin
          b = (fq[i].size() == 0) ? 8'h00 : fq[i].pop_front();
          if (i == 0) rd_data[i] = b;
          else        s1[i] = b;
        end
      end
      empty[i] = (fq[i].size() == 0);
    end
  endtask

  // Compare one DUT against the burst-level model, then advance the model.
  task automatic compare_one(input int i);
    int   lat;
    logic hsk, was_idle;
    lat = i + 1;
    chk($sformatf("busy[%0d]", i), busy[i], mb_busy[i]);
    chk($sformatf("done[%0d]", i), done[i], mb_done[i]);
    if (rd_en[i]) begin
      chk($sformatf("rd_en_on_empty[%0d]", i), empty[i], 0);
      chk($sformatf("rd_en_outside_burst[%0d]", i), mb_busy[i], 1);
      chk($sformatf("reads_within_len[%0d]", i), reads[i] < len_cur[i], 1);
      chk($sformatf("occupancy[%0d]", i), (reads[i] + 1 - hs[i]) <= c_DEPTH, 1);
    end
    if (m_valid[i]) begin
      chk($sformatf("valid_in_burst[%0d]", i), mb_busy[i], 1);
      if (exp_q[i].size() == 0) chk($sformatf("valid_without_data[%0d]", i), 1, 0);
      else chk($sformatf("m_data[%0d]", i), m_data[i], exp_q[i][0]);
      chk($sformatf("m_last[%0d]", i), m_last[i], rem_out[i] == 1);
      if (first_valid[i] < 0) begin
        first_valid[i] = idx[i];
        if (first_rd[i] >= 0)
          chk($sformatf("first_valid_latency[%0d]", i), idx[i] - first_rd[i], lat + 1);
      end
    end else begin
      chk($sformatf("last_without_valid[%0d]", i), m_last[i], 0);
    end
    if (prev_stall[i]) begin
      chk($sformatf("stall_valid[%0d]", i), m_valid[i], 1);
      chk($sformatf("stall_data[%0d]", i), m_data[i], prev_data[i]);
      chk($sformatf("stall_last[%0d]", i), m_last[i], prev_last[i]);
    end

    hsk           = m_valid[i] && m_ready;
    prev_stall[i] = m_valid[i] && !m_ready;
    prev_data[i]  = m_data[i];
    prev_last[i]  = m_last[i];
    rd_en_s[i]    = rd_en[i];
    if (!rst_n) begin
      mb_busy[i] = 1'b0;
      mb_done[i] = 1'b0;
      rem_out[i] = 0;
      prev_stall[i] = 1'b0;
      exp_q[i].delete();
    end else begin
      was_idle = !mb_busy[i] && !mb_done[i];
      if (mb_done[i]) mb_done[i] = 1'b0;
      if (rd_en[i]) begin
        if (first_rd[i] < 0) first_rd[i] = idx[i];
        reads[i]++;
      end
      if (hsk) begin
        last_byte[i] = m_data[i];
        hs[i]++;
        if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
        rem_out[i]--;
        if (rem_out[i] == 0) begin
          mb_busy[i] = 1'b0;
          mb_done[i] = 1'b1;
          done_seen[i] = 1'b1;
          last_hs_idx[i] = idx[i];
          chk($sformatf("reads_per_burst[%0d]", i), reads[i], len_cur[i]);
        end
      end
      if (was_idle && start && (burst_len != '0)) begin
        mb_busy[i] = 1'b1;
        rem_out[i] = int'(burst_len);
        len_cur[i] = int'(burst_len);
        reads[i] = 0;
        hs[i] = 0;
        idx[i] = -1;
        first_rd[i] = -1;
        first_valid[i] = -1;
      end
      idx[i]++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: FIFO update after the edge, drive and compare mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
    fifo_edge();
    @(negedge clk);
    rst_n = drv_rst_n;
    start = drv_start;
    burst_len = drv_len;
    m_ready = drv_ready;
    if (drv_push) begin
      for (int i = 0; i < 2; i++)
        for (int b = 0; b < 4; b++) begin
          fq[i].push_back(drv_word[8*b +: 8]);
          exp_q[i].push_back(drv_word[8*b +: 8]);
        end
    end
    drv_push = 1'b0;
    for (int i = 0; i < 2; i++) empty[i] = (fq[i].size() == 0);
    #1;
    for (int i = 0; i < 2; i++) compare_one(i);
  endtask

  task automatic do_reset();
    drv_rst_n = 1'b0;
    step();
    drv_rst_n = 1'b1;
    step();
  endtask

  task automatic push_word(input logic [31:0] w);
    drv_push = 1'b1;
    drv_word = w;
    step();
  endtask

  // Preload n words carrying consecutive bytes starting at 0.
  task automatic preload(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = 8'(4 * k);
      push_word({b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
  endtask

  task automatic pulse_start(input int len);
    drv_start = 1'b1;
    drv_len = c_LW'(len);
    done_seen[0] = 1'b0;
    done_seen[1] = 1'b0;
    step();
    drv_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!(done_seen[0] && done_seen[1]) && n < budget) begin
      step();
      n++;
    end
    if (!(done_seen[0] && done_seen[1])) chk({name, "_timeout"}, 0, 1);
    step();
    step();
  endtask

  task automatic chk_all_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_busy[%0d]", name, i), busy[i], 0);
      chk($sformatf("%s_done[%0d]", name, i), done[i], 0);
      chk($sformatf("%s_valid[%0d]", name, i), m_valid[i], 0);
      chk($sformatf("%s_last[%0d]", name, i), m_last[i], 0);
      chk($sformatf("%s_data[%0d]", name, i), m_data[i], 0);
      chk($sformatf("%s_rd_en[%0d]", name, i), rd_en[i], 0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    int n;
    logic [31:0] w;
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; burst_len = '0;
    drv_rst_n = 1'b0; drv_start = 1'b0; drv_ready = 1'b1; drv_push = 1'b0;
    drv_len = '0; drv_word = '0;
    for (int i = 0; i < 2; i++) begin
      s1[i] = '0; rd_data[i] = '0; empty[i] = 1'b1; rd_en_s[i] = 1'b0;
      mb_busy[i] = 1'b0; mb_done[i] = 1'b0; done_seen[i] = 1'b0;
      rem_out[i] = 0; len_cur[i] = 0; reads[i] = 0; hs[i] = 0; idx[i] = 0;
      first_rd[i] = -1; first_valid[i] = -1; last_hs_idx[i] = 0; last_byte[i] = 0;
      prev_stall[i] = 1'b0; prev_last[i] = 1'b0; prev_data[i] = '0;
    end
    repeat (2) @(posedge clk);

    // 1: back-to-back 64-byte burst from a preloaded FIFO.
    do_reset();
    chk_all_zero("reset");
    preload(16);
    drv_ready = 1'b1;
    pulse_start(64);
    wait_done(400, "t1");
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t1_reads[%0d]", i), reads[i], 64);
      chk($sformatf("t1_first_valid[%0d]", i), first_valid[i], i + 2);
      chk($sformatf("t1_last_byte[%0d]", i), last_byte[i], 8'h3F);
      chk($sformatf("t1_streaming[%0d]", i), last_hs_idx[i] - first_valid[i], 63);
    end

    // 2: backpressure, ready toggling then held low.
    do_reset();
    preload(4);
    drv_ready = 1'b1;
    pulse_start(16);
    for (int c = 0; c < 20; c++) begin
      drv_ready = (c % 2 == 1);
      step();
    end
    drv_ready = 1'b0;
    repeat (10) step();
    drv_ready = 1'b1;
    wait_done(200, "t2");
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t2_last_byte[%0d]", i), last_byte[i], 8'h0F);
      chk($sformatf("t2_bytes[%0d]", i), hs[i], 16);
    end

    // 3: starved FIFO, one word every 20 cycles.
    do_reset();
    drv_ready = 1'b1;
    pulse_start(8);
    n = 0;
    while (!(done_seen[0] && done_seen[1]) && n < 200) begin
      if (n % 20 == 0) begin
        drv_push = 1'b1;
        drv_word = 32'h44332211;
      end
      step();
      n++;
    end
    if (!(done_seen[0] && done_seen[1])) chk("t3_timeout", 0, 1);
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t3_last_byte[%0d]", i), last_byte[i], 8'h44);
      chk($sformatf("t3_reads[%0d]", i), reads[i], 8);
    end

    // 4: short burst from a full FIFO.
    do_reset();
    preload(16);
    pulse_start(5);
    wait_done(100, "t4");
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t4_first_valid[%0d]", i), first_valid[i], i + 2);
      chk($sformatf("t4_reads[%0d]", i), reads[i], 5);
      chk($sformatf("t4_last_byte[%0d]", i), last_byte[i], 8'h04);
    end

    // 5: reset after three bytes, then a fresh 2-byte burst.
    do_reset();
    preload(3);
    pulse_start(10);
    n = 0;
    while (hs[0] < 3 && n < 50) begin
      step();
      n++;
    end
    chk("t5_three_bytes", hs[0], 3);
    drv_rst_n = 1'b0;
    step();
    drv_rst_n = 1'b1;
    step();
    chk_all_zero("t5_after_reset");
    push_word(32'hDDCCBBAA);
    pulse_start(2);
    wait_done(50, "t5");
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t5_bytes[%0d]", i), hs[i], 2);
      chk($sformatf("t5_last_byte[%0d]", i), last_byte[i], 8'hBB);
    end

    // 6: zero length ignored; a start during a burst is ignored.
    do_reset();
    preload(8);
    pulse_start(0);
    for (int c = 0; c < 3; c++) begin
      step();
      for (int i = 0; i < 2; i++) chk($sformatf("t6_zero_busy[%0d]", i), busy[i], 0);
    end
    pulse_start(6);
    step();
    drv_start = 1'b1;
    drv_len = c_LW'(20);
    step();
    drv_start = 1'b0;
    wait_done(100, "t6");
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t6_bytes[%0d]", i), hs[i], 6);
      chk($sformatf("t6_last_byte[%0d]", i), last_byte[i], 8'h05);
    end

    // Random bursts with random ready and random FIFO arrivals.
    do_reset();
    for (int b = 0; b < 8; b++) begin
      drv_ready = 1'b1;
      pulse_start(int'($urandom_range(1, 20)));
      n = 0;
      while (!(done_seen[0] && done_seen[1]) && n < 600) begin
        drv_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) == 0 && fq[0].size() < 56 && fq[1].size() < 56) begin
          w = $urandom;
          drv_push = 1'b1;
          drv_word = w;
        end
        step();
        n++;
      end
      if (!(done_seen[0] && done_seen[1])) chk("rand_timeout", 0, 1);
      drv_ready = 1'b1;
      step();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
